// File: rtl/memd_responder_pkg.sv
// Shared definitions for the data-memory read responder.
//
// Holds the machine-wide sizes the core already uses (memory, register and
// ROB widths), the responder's default latency and queue depth, and the
// helper that gives the reset value of every data-memory word.
package memd_responder_pkg;

    localparam int MEMD_SIZE_LOG = 2;
    localparam int MEMD_SIZE     = 1 << MEMD_SIZE_LOG;
    localparam int REG_LEN       = 2;
    localparam int ROB_SIZE_LOG  = 2;

    // Defaults for the responder instance in the core.
    localparam int MEMD_LATENCY  = 2;
    localparam int MEMD_QDEPTH   = 4;

`ifdef INIT_MEMD_CUSTOMIZED
    localparam bit MEMD_INIT_CUSTOM = 1'b1;
`else
    localparam bit MEMD_INIT_CUSTOM = 1'b0;
`endif

    // Reset image of the data memory. The customised image is {0,1,0,0}
    // in words 0..3; every other word (and every word of the plain image)
    // is zero.
    function automatic int unsigned memd_init_word(input int unsigned idx,
                                                   input bit          custom);
        if (custom && idx == 1) begin
            return 1;
        end
        return 0;
    endfunction

endpackage

// File: rtl/memd_responder_resp_fifo.sv
// resp_fifo: width-by-depth synchronous FIFO for buffered load responses.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset (also clears storage)
//   clear      - drops every entry at the next edge, storage left as is
//   push       - write push_data at the tail (caller never pushes when full)
//   push_data  - entry to write
//   pop        - advance the head (ignored while empty)
//   empty      - no entry buffered
//   head_data  - oldest entry, combinational from storage
module resp_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]            head_reg;
    logic [PTR_W-1:0]            tail_reg;
    logic [PTR_W:0]              count_reg;
    logic [PTR_W:0]              count_next;
    logic [DEPTH-1:0][WIDTH-1:0] store;
    logic                        pop_eff;

    assign empty   = (count_reg == '0);
    assign pop_eff = pop && !empty;

    // One register per entry; storage is cleared on reset so the head
    // presents zeros until the first response arrives.
    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                entry_reg <= '0;
            end else if (push && (tail_reg == PTR_W'(gi))) begin
                entry_reg <= push_data;
            end
        end

        assign store[gi] = entry_reg;
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop_eff})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop_eff) begin
                head_reg <= head_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    assign head_data = store[head_reg];

endmodule

// File: rtl/memd_responder.sv
// memd_responder: responder end of the data-memory read channel.
//
// Accepts tagged load requests, reads the read-only data memory in the
// accept cycle, delays data+tag by a fixed LATENCY and buffers the result in
// a response FIFO released under valid/ready. A credit counter bounds the
// number of loads in flight to QDEPTH so the FIFO never overflows. flush
// squashes every in-flight and buffered load.
//
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   flush                  - squash all in-flight/buffered responses
//   req_valid/req_ready    - request handshake
//   req_addr, req_tag      - word address and ROB index of the load
//   resp_valid/resp_ready  - response handshake
//   resp_data, resp_tag    - loaded word and its tag (FIFO head)
module memd_responder #(
    parameter int MEMD_SIZE_LOG = memd_responder_pkg::MEMD_SIZE_LOG,
    parameter int REG_LEN       = memd_responder_pkg::REG_LEN,
    parameter int TAG_LEN       = memd_responder_pkg::ROB_SIZE_LOG,
    parameter int LATENCY       = memd_responder_pkg::MEMD_LATENCY,
    parameter int QDEPTH        = memd_responder_pkg::MEMD_QDEPTH,
    parameter bit INIT_CUSTOM   = memd_responder_pkg::MEMD_INIT_CUSTOM
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [MEMD_SIZE_LOG-1:0] req_addr,
    input  logic [TAG_LEN-1:0]       req_tag,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [REG_LEN-1:0]       resp_data,
    output logic [TAG_LEN-1:0]       resp_tag
);

    import memd_responder_pkg::*;

    localparam int WORDS   = 1 << MEMD_SIZE_LOG;
    localparam int PTR_W   = $clog2(QDEPTH);
    localparam int OUT_W   = PTR_W + 1;
    localparam int STAGES  = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam int ENTRY_W = REG_LEN + TAG_LEN;

    logic [WORDS-1:0][REG_LEN-1:0] memd_words;
    logic [REG_LEN-1:0]            rd_data;
    logic                          accept;
    logic                          pop;
    logic                          fifo_empty;
    logic                          fifo_push;
    logic [ENTRY_W-1:0]            fifo_push_data;
    logic [ENTRY_W-1:0]            fifo_head;
    logic [OUT_W-1:0]              outstanding_reg;
    logic [OUT_W-1:0]              outstanding_next;

    // ------------------------------------------------------------------
    // Data memory: read-only, loaded with its image on reset and never
    // written afterwards. Flush leaves it untouched.
    // ------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < WORDS; gi++) begin : g_word
        logic [REG_LEN-1:0] word_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                word_reg <= REG_LEN'(memd_init_word(gi, INIT_CUSTOM));
            end
        end

        assign memd_words[gi] = word_reg;
    end

    assign rd_data = memd_words[req_addr];

    // ------------------------------------------------------------------
    // Handshakes. Flush blocks both accept and pop in its own cycle; the
    // credit check deliberately ignores resp_ready so a pop only frees a
    // slot from the following cycle.
    // ------------------------------------------------------------------
    assign req_ready  = !flush && (outstanding_reg < OUT_W'(QDEPTH));
    assign accept     = req_valid && req_ready;
    assign resp_valid = !fifo_empty;
    assign pop        = resp_valid && resp_ready && !flush;

    // ------------------------------------------------------------------
    // Delay pipeline: LATENCY-1 stages with no stall; the last stage (or
    // the accept itself for LATENCY==1) writes the FIFO.
    // ------------------------------------------------------------------
    if (LATENCY == 1) begin : g_direct
        assign fifo_push      = accept;
        assign fifo_push_data = {rd_data, req_tag};
    end else begin : g_pipe
        logic [STAGES-1:0]              stage_valid_reg;
        logic [STAGES-1:0][REG_LEN-1:0] stage_data_reg;
        logic [STAGES-1:0][TAG_LEN-1:0] stage_tag_reg;

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                stage_valid_reg <= '0;
            end else begin
                stage_valid_reg[0] <= accept;
                for (int i = 1; i < STAGES; i++) begin
                    stage_valid_reg[i] <= stage_valid_reg[i-1];
                end
            end
        end

        // Payload only matters where the valid bit is set, so it moves
        // every cycle without reset.
        always_ff @(posedge clk) begin
            stage_data_reg[0] <= rd_data;
            stage_tag_reg[0]  <= req_tag;
            for (int i = 1; i < STAGES; i++) begin
                stage_data_reg[i] <= stage_data_reg[i-1];
                stage_tag_reg[i]  <= stage_tag_reg[i-1];
            end
        end

        assign fifo_push      = stage_valid_reg[STAGES-1];
        assign fifo_push_data = {stage_data_reg[STAGES-1], stage_tag_reg[STAGES-1]};
    end

    // ------------------------------------------------------------------
    // Response FIFO. Credits guarantee a free slot for every push.
    // ------------------------------------------------------------------
    resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (pop),
        .empty     (fifo_empty),
        .head_data (fifo_head)
    );

    assign resp_data = fifo_head[ENTRY_W-1:TAG_LEN];
    assign resp_tag  = fifo_head[TAG_LEN-1:0];

    // ------------------------------------------------------------------
    // Credit counter: loads accepted but not yet handed back.
    // ------------------------------------------------------------------
    always_comb begin
        outstanding_next = outstanding_reg;
        if (accept && !pop) begin
            outstanding_next = outstanding_reg + 1'b1;
        end else if (pop && !accept) begin
            outstanding_next = outstanding_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            outstanding_reg <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
        end
    end

endmodule
